// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the SIPO frame sequencer: state encoding,
// default frame geometry and a helper computing strobes per frame.
package sipo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2,
    VALID = 2'd3
  } state_t;

  localparam int unsigned DEF_FRAME_BITS = 32'd8;
  localparam int unsigned DEF_BIT_DIV    = 32'd4;
  localparam int unsigned DEF_CNT_W      = 32'd8;

  // Number of cs strobes in one frame; a trailing parity bit adds one.
  function automatic int unsigned total_strobes(input int unsigned frame_bits,
                                                input bit parity_en);
    return parity_en ? (frame_bits + 32'd1) : frame_bits;
  endfunction

endpackage

// File: rtl/bit_rate_div.sv
// Serial bit-period divider. Counts 0..DIV-1 while enabled and produces a
// registered strobe during the cycle in which the count equals DIV-1.
// Clear and enable together restart the count at 0 as an active cycle.
module bit_rate_div #(
  parameter int unsigned DIV = 32'd4,
  parameter int unsigned W   = 32'd8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_strobe
);

  localparam logic [W-1:0] LAST    = W'(DIV - 32'd1);
  localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;
  logic [W-1:0] w_cnt_nxt;
  logic         r_strobe;

  // Next divider value: clear, wrap at DIV-1, or hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = {W{1'b0}};
    end else if (i_en) begin
      if (r_cnt == LAST) begin
        w_cnt_nxt = {W{1'b0}};
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Count register and pre-decoded strobe for the coming cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= {W{1'b0}};
      r_strobe <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_strobe <= i_en && (w_cnt_nxt == LAST);
    end
  end

  assign o_strobe = r_strobe;

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame sequencer for the sine-datapath SIPO register: shift strobes once per
// bit period, one-cycle parallel load, then valid/ready hand-off of PDATA.
// Optional macro SIPO_FRAME_PARITY_EN adds an even-parity bit per frame with
// ports i_sdi / o_parity_err.
module sipo_frame_ctrl
  import sipo_ctrl_pkg::*;
#(
  parameter int unsigned FRAME_BITS = DEF_FRAME_BITS,
  parameter int unsigned BIT_DIV    = DEF_BIT_DIV,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_cs,
  output logic             o_not_ld,
  output logic             o_pdata_valid,
  input  logic             i_pdata_ready,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_bit_cnt,
  output logic             o_overrun
`ifdef SIPO_FRAME_PARITY_EN
  ,
  input  logic             i_sdi,
  output logic             o_parity_err
`endif
);

`ifdef SIPO_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int unsigned      N_STROBES = total_strobes(FRAME_BITS, PAR_EN);
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(N_STROBES - 32'd1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(N_STROBES);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic             r_not_ld;
  logic             r_pdata_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_bit_cnt;
  logic             r_overrun;

  logic w_cs;
  logic w_start_ok;
  logic w_last_strobe;
  logic w_shift_cont;
  logic w_div_en;
  logic w_div_clr;

  // abort beats start in IDLE; the divider keeps running only while the
  // frame stays in SHIFT, and restarts from 0 on an accepted start.
  assign w_start_ok    = (r_state == IDLE) && i_start && !i_abort;
  assign w_last_strobe = w_cs && (r_bit_cnt == LAST_BIT);
  assign w_shift_cont  = (r_state == SHIFT) && !i_abort && !w_last_strobe;
  assign w_div_en      = w_start_ok || w_shift_cont;
  assign w_div_clr     = !w_shift_cont;

  bit_rate_div #(
    .DIV (BIT_DIV),
    .W   (CNT_W)
  ) u_div (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_div_clr),
    .i_en     (w_div_en),
    .o_strobe (w_cs)
  );

  // Frame FSM with registered load/valid/busy, bit counter and sticky overrun.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_not_ld      <= 1'b0;
      r_pdata_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_bit_cnt     <= {CNT_W{1'b0}};
      r_overrun     <= 1'b0;
    end else begin
      if (i_start && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_not_ld      <= 1'b0;
          r_pdata_valid <= 1'b0;
          if (w_start_ok) begin
            r_state   <= SHIFT;
            r_busy    <= 1'b1;
            r_bit_cnt <= {CNT_W{1'b0}};
          end else begin
            r_busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (i_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= {CNT_W{1'b0}};
          end else if (w_cs) begin
            if (r_bit_cnt != FULL_CNT) begin
              r_bit_cnt <= r_bit_cnt + CNT_ONE;
            end
            if (r_bit_cnt == LAST_BIT) begin
              r_state  <= LOAD;
              r_not_ld <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_not_ld <= 1'b0;
          if (i_abort) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_bit_cnt <= {CNT_W{1'b0}};
          end else begin
            r_state       <= VALID;
            r_pdata_valid <= 1'b1;
          end
        end
        VALID: begin
          if (i_pdata_ready) begin
            r_state       <= IDLE;
            r_pdata_valid <= 1'b0;
            r_busy        <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_not_ld      <= 1'b0;
          r_pdata_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_bit_cnt     <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign o_cs          = w_cs;
  assign o_not_ld      = r_not_ld;
  assign o_pdata_valid = r_pdata_valid;
  assign o_busy        = r_busy;
  assign o_bit_cnt     = r_bit_cnt;
  assign o_overrun     = r_overrun;

`ifdef SIPO_FRAME_PARITY_EN
  logic r_par_acc;
  logic r_parity_err;

  // XOR-accumulate serial bits on each strobe; publish the result with the load.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_par_acc    <= 1'b0;
      r_parity_err <= 1'b0;
    end else if (w_start_ok) begin
      r_par_acc    <= 1'b0;
      r_parity_err <= 1'b0;
    end else if ((r_state == SHIFT) && w_cs) begin
      r_par_acc <= r_par_acc ^ i_sdi;
    end else if ((r_state == LOAD) && !i_abort) begin
      r_parity_err <= r_par_acc;
    end
  end

  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl: a BIT_DIV=4 instance driving a
// behavioural SIPO register, and a BIT_DIV=1 instance for the fast path.
module tb_sipo_frame_ctrl;

`ifdef SIPO_FRAME_PARITY_EN
  localparam int TXL = 9;
`else
  localparam int TXL = 8;
`endif
  localparam int DIV0 = 4;
  localparam int L0   = DIV0 * TXL;
  localparam logic [8:0] TX_MASK = (TXL == 9) ? 9'h1FF : 9'h0FF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, abort0 = 1'b0, ready0 = 1'b1;
  logic       start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b1;
  logic       cs0, nld0, val0, busy0, ovr0;
  logic       cs1, nld1, val1, busy1, ovr1;
  logic [7:0] bc0, bc1;
  logic       sdi0;
  logic [8:0] tx_word = 9'h000;
  logic [8:0] sipo_q  = 9'h000;
  logic [8:0] pdata   = 9'h000;
`ifdef SIPO_FRAME_PARITY_EN
  logic       sdi1 = 1'b0;
  logic       perr0, perr1;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Serial source: next frame bit, MSB first, chosen by the bits already sent.
  assign sdi0 = (int'(bc0) < TXL) ? tx_word[TXL - 1 - int'(bc0)] : 1'b0;

  // Behavioural SIPO: shift on cs, capture q into PDATA on not_ld.
  always @(posedge clk) begin
    if (cs0) sipo_q <= {sipo_q[7:0], sdi0};
    if (nld0) pdata <= sipo_q;
  end

  sipo_frame_ctrl #(.FRAME_BITS(8), .BIT_DIV(DIV0), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_abort(abort0),
    .o_cs(cs0), .o_not_ld(nld0), .o_pdata_valid(val0), .i_pdata_ready(ready0),
    .o_busy(busy0), .o_bit_cnt(bc0), .o_overrun(ovr0)
`ifdef SIPO_FRAME_PARITY_EN
    , .i_sdi(sdi0), .o_parity_err(perr0)
`endif
  );

  sipo_frame_ctrl #(.FRAME_BITS(8), .BIT_DIV(1), .CNT_W(8)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_abort(abort1),
    .o_cs(cs1), .o_not_ld(nld1), .o_pdata_valid(val1), .i_pdata_ready(ready1),
    .o_busy(busy1), .o_bit_cnt(bc1), .o_overrun(ovr1)
`ifdef SIPO_FRAME_PARITY_EN
    , .i_sdi(sdi1), .o_parity_err(perr1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] make_word(input logic [7:0] b);
    return (TXL == 9) ? {b, ^b} : {1'b0, b};
  endfunction

  // One full frame on u_dut with ready high; checks every cycle.
  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_frame(input logic [8:0] w, input int pulse_at);
    int e;
    tx_word = w;
    ready0  = 1'b1;
    start0  = 1'b1;
    for (int k = 1; k <= L0 + 3; k++) begin
      @(negedge clk);
      start0 = (k == pulse_at);
      e = (k - 1) / DIV0;
      if (e > TXL) e = TXL;
      chk("cs",      32'(cs0),   32'((k % DIV0 == 0) && (k <= L0)));
      chk("not_ld",  32'(nld0),  32'(k == L0 + 1));
      chk("valid",   32'(val0),  32'(k == L0 + 2));
      chk("busy",    32'(busy0), 32'(k <= L0 + 2));
      chk("bit_cnt", 32'(bc0),   32'(e));
      chk("cs_ld_excl", 32'(cs0 & nld0), 32'd0);
      if (k == L0 + 2) begin
        chk("pdata", 32'(pdata & TX_MASK), 32'(w));
`ifdef SIPO_FRAME_PARITY_EN
        chk("parity_err0", 32'(perr0), 32'd0);
`endif
      end
    end
  endtask

  // One frame on the BIT_DIV=1 instance, serial bits fed per cycle.
  task automatic run_fast(input logic [8:0] w, input logic exp_perr);
    start1 = 1'b1;
    for (int k = 1; k <= TXL + 3; k++) begin
      @(negedge clk);
      start1 = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
      sdi1 = (k <= TXL) ? w[TXL - k] : 1'b0;
`endif
      chk("fast_cs",    32'(cs1),  32'(k <= TXL));
      chk("fast_ld",    32'(nld1), 32'(k == TXL + 1));
      chk("fast_valid", 32'(val1), 32'(k == TXL + 2));
`ifdef SIPO_FRAME_PARITY_EN
      if (k == TXL + 2) chk("parity_err1", 32'(perr1), 32'(exp_perr));
`else
      if (k == TXL + 2) chk("fast_bit_cnt", 32'(bc1), 32'(TXL + {31'd0, exp_perr}));
`endif
    end
  endtask

  initial begin
    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_cs",      32'(cs0),   32'd0);
    chk("rst_not_ld",  32'(nld0),  32'd0);
    chk("rst_valid",   32'(val0),  32'd0);
    chk("rst_busy",    32'(busy0), 32'd0);
    chk("rst_bit_cnt", 32'(bc0),   32'd0);
    chk("rst_overrun", 32'(ovr0),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic frame, ready tied high.
    run_frame(make_word(8'hA5), 0);
    chk("overrun_clean", 32'(ovr0), 32'd0);

    // Consumer stalls 10 cycles in VALID.
    tx_word = make_word(8'h3C);
    ready0  = 1'b0;
    start0  = 1'b1;
    for (int k = 1; k <= L0 + 1; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(val0), 32'd1);
      chk("stall_pdata", 32'(pdata & TX_MASK), 32'(make_word(8'h3C)));
    end
    @(negedge clk);
    chk("hs_valid", 32'(val0), 32'd1);
    ready0 = 1'b1;
    @(negedge clk);
    chk("post_hs_valid", 32'(val0),  32'd0);
    chk("post_hs_busy",  32'(busy0), 32'd0);

    // Abort after the 5th strobe.
    tx_word = make_word(8'h0F);
    start0  = 1'b1;
    for (int k = 1; k <= 5 * DIV0 + 1; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("pre_abort_bit_cnt", 32'(bc0), 32'd5);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_busy",    32'(busy0), 32'd0);
    chk("abort_bit_cnt", 32'(bc0),   32'd0);
    chk("abort_cs",      32'(cs0),   32'd0);
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk("abort_no_ld",    32'(nld0), 32'd0);
      chk("abort_no_valid", 32'(val0), 32'd0);
    end
    chk("abort_pdata_kept", 32'(pdata & TX_MASK), 32'(make_word(8'h3C)));
    run_frame(make_word(8'h5A), 0);

    // start during SHIFT: sticky overrun, frame still completes.
    run_frame(make_word(8'hC3), 10);
    chk("overrun_set", 32'(ovr0), 32'd1);
    repeat (3) @(negedge clk);
    chk("overrun_sticky", 32'(ovr0), 32'd1);

    // start and abort together in IDLE: abort wins.
    start0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("start_abort_busy", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("start_abort_cs", 32'(cs0), 32'd0);

    // Asynchronous reset in the middle of bit 3.
    start0 = 1'b1;
    for (int k = 1; k <= 3 * DIV0 + 2; k++) begin
      @(negedge clk);
      start0 = 1'b0;
    end
    chk("pre_rst_bit_cnt", 32'(bc0), 32'd3);
    rst = 1'b1;
    #1;
    chk("arst_busy",    32'(busy0), 32'd0);
    chk("arst_bit_cnt", 32'(bc0),   32'd0);
    chk("arst_overrun", 32'(ovr0),  32'd0);
    chk("arst_cs",      32'(cs0),   32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      chk("arst_no_ld", 32'(nld0),  32'd0);
      chk("arst_idle",  32'(busy0), 32'd0);
    end

    // BIT_DIV=1 fast path.
`ifdef SIPO_FRAME_PARITY_EN
    run_fast({8'hA5, 1'b0}, 1'b0);
    run_fast({8'hA5, 1'b1}, 1'b1);
`else
    run_fast(make_word(8'hA5), 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
Name: sipo_frame_ctrl

Overview:
- Sequencer for the SIPO shift register in the sine-wave datapath. Accepts a frame request, strobes the register's shift enable once per serial bit period for exactly FRAME_BITS bits, then pulses the parallel-load control.
- Presents the captured word to a downstream consumer through a valid/ready handshake.
- Sits between the serial-input front end and the sample/phase-register logic.

Parameters:
- FRAME_BITS, 8, bits per frame; equals the SIPO width N+1; range 2..64.
- BIT_DIV, 4, clk cycles per serial bit; range 1..256; shift strobe on the last cycle of each bit period.
- CNT_W, 8, width of bit and divider counters; must hold max(FRAME_BITS, BIT_DIV).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE without load.
- cs  out  1  to SIPO CS; one-cycle shift strobe per bit.
- not_ld  out  1  to SIPO NOT_LD; high for one cycle means the SIPO captures q into PDATA at the next edge.
- pdata_valid  out  1  SIPO PDATA holds a new frame.
- pdata_ready  in  1  consumer accepts when valid&&ready.
- busy  out  1  high in every state except IDLE.
- bit_cnt  out  CNT_W  bits shifted in the current frame.
- overrun  out  1  sticky; start seen while not IDLE; cleared only by rst.

Behaviour:
- Async reset (rst=1): state=IDLE; cs=0, not_ld=0, pdata_valid=0, busy=0, bit_cnt=0, overrun=0, divider=0. All outputs are registered.
- IDLE: start=1 -> SHIFT, divider=0, bit_cnt=0. Otherwise hold.
- SHIFT:
  - Divider counts 0..BIT_DIV-1 and wraps.
  - cs=1 for exactly one cycle when divider==BIT_DIV-1; bit_cnt increments on that cycle.
  - BIT_DIV=1 gives cs=1 every cycle.
  - When the strobe that makes bit_cnt==FRAME_BITS is issued -> LOAD.
- LOAD: not_ld=1 for exactly one cycle, cs=0 -> VALID. The first cycle of LOAD immediately follows the last cs cycle, so the SIPO q already holds the full frame.
- VALID:
  - pdata_valid=1, held stable until pdata_ready=1.
  - Handshake cycle -> IDLE; pdata_valid drops the next cycle.
  - Latency from start to pdata_valid: FRAME_BITS*BIT_DIV + 2 cycles.
- A new frame may start no earlier than the cycle after the handshake. start held high restarts back to back with a 1-cycle IDLE gap.
- abort=1 in SHIFT or LOAD -> IDLE next cycle; cs and not_ld are forced 0 that cycle; bit_cnt=0. abort in VALID is ignored because data is already loaded.
- start=1 and abort=1 together in IDLE: abort wins and the state stays IDLE.
- start=1 in any non-IDLE state sets overrun and is otherwise ignored.
- cs and not_ld are never high in the same cycle.
- The bit counter saturates at FRAME_BITS and never wraps.

Optional Feature:
- Macro SIPO_FRAME_PARITY_EN.
- When defined:
  - The frame is FRAME_BITS+1 strobes; the last bit is even parity.
  - The controller samples sdi (extra 1-bit input port) on each cs cycle and XOR-accumulates it.
  - A new output parity_err is valid with pdata_valid: 1 when the accumulated XOR over all FRAME_BITS+1 bits != 0.
  - The load still occurs. The parity bit is shifted into the SIPO, so the SIPO width must be FRAME_BITS+1.
- When undefined: no sdi or parity_err ports; behaviour exactly as above.

Decomposition:
- Shared package sipo_ctrl_pkg holds:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, LOAD=2'd2, VALID=2'd3;
  - default FRAME_BITS and BIT_DIV constants.
- One natural sub-module, bit_rate_div: a divider that produces the one-cycle strobe, with enable and synchronous clear.
- The FSM and counters stay in the top module.

Test Plan:
- Reset mid-SHIFT (rst pulsed asynchronously at bit 3) -> all outputs 0 immediately, state IDLE, no not_ld pulse.
- FRAME_BITS=8, BIT_DIV=4, start pulse, ready tied 1 -> exactly 8 cs pulses spaced 4 cycles apart, then not_ld one cycle, then pdata_valid at cycle 34 after start; SIPO PDATA equals the 8 serial bits, MSB first.
- ready held 0 for 10 cycles in VALID -> pdata_valid stays 1 and PDATA stays stable; handshake on cycle 11 -> IDLE.
- abort asserted after the 5th cs -> no not_ld; bit_cnt=0; PDATA unchanged from the previous frame; the next start completes a full 8-bit frame.
- start pulsed during SHIFT -> overrun=1 and sticky; the current frame completes normally.
- BIT_DIV=1, with SIPO_FRAME_PARITY_EN: pattern 0xA5 plus parity 0 -> parity_err=0; parity 1 -> parity_err=1; cs high 9 consecutive cycles.
